// File: rtl/program_loader_pkg.sv
// Shared definitions for the byte-stream program loader.
package program_loader_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CSUM,
    ST_RESP
  } state_e;

  // Header: 2-byte word count followed by 2-byte start address.
  localparam int HDR_LEN        = 4;
  // Payload bytes per 32-bit memory word.
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_word_packer.sv
// Assembles little-endian payload bytes into 32-bit words and emits a
// one-cycle word-valid pulse on the cycle after the fourth byte lands.
module program_loader_word_packer
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;

  assign last_byte_o  = byte_en_i && (byte_idx_q == 2'(BYTES_PER_WORD - 1));
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

  // Next-state: shift bytes in from the top so byte k ends at bits [8k+7:8k].
  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    byte_idx_d   = byte_idx_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (byte_en_i) begin
      byte_idx_d = byte_idx_q + 2'd1;
      shift_d    = {byte_i, shift_q[23:8]};
      if (last_byte_o) begin
        word_d       = {byte_i, shift_q};
        word_valid_d = 1'b1;
      end
    end
  end

  // State register; a reset drops any pending word-valid pulse.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q   <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      byte_idx_q   <= byte_idx_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream program loader: parses header, writes payload words
// to memory, verifies an XOR checksum and releases the CPU hold on success.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic                  busy
);

  state_e                  state_q, state_d;
  logic [1:0]              hdr_idx_q, hdr_idx_d;
  logic [23:0]             hdr_q, hdr_d;
  logic [15:0]             words_left_q, words_left_d;
  logic [ADDR_WIDTH-1:0]   addr_ptr_q, addr_ptr_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]              csum_q, csum_d;
  logic                    cpu_hold_q, cpu_hold_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic                    accept;
  logic                    last_byte;
  logic [31:0]             word;

  // Only the response cycle refuses a byte.
  assign in_ready = (state_q != ST_RESP);
  assign accept   = in_valid && in_ready;

  program_loader_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_en_i    (accept && (state_q == ST_DATA)),
    .byte_i       (in_data),
    .last_byte_o  (last_byte),
    .word_valid_o (mem_we),
    .word_o       (word)
  );

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = DATA_WIDTH'(word);
  assign cpu_hold  = cpu_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

  // Next-state and output logic for the frame sequencer.
  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    hdr_d        = hdr_q;
    words_left_d = words_left_q;
    addr_ptr_d   = addr_ptr_q;
    mem_addr_d   = mem_addr_q;
    csum_d       = csum_q;
    cpu_hold_d   = cpu_hold_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_d    = ST_HDR;
        hdr_idx_d  = 2'd1;
        hdr_d      = {in_data, hdr_q[23:8]};
        csum_d     = in_data;
        cpu_hold_d = 1'b1;
        busy_d     = 1'b1;
      end
      ST_HDR: if (accept) begin
        csum_d    = csum_q ^ in_data;
        hdr_idx_d = hdr_idx_q + 2'd1;
        if (hdr_idx_q == 2'(HDR_LEN - 1)) begin
          // Bytes 0..2 sit in hdr_q; this byte is the address high byte.
          words_left_d = hdr_q[15:0];
          addr_ptr_d   = ADDR_WIDTH'({in_data, hdr_q[23:16]});
          state_d      = (hdr_q[15:0] != 16'd0) ? ST_DATA : ST_CSUM;
        end else begin
          hdr_d = {in_data, hdr_q[23:8]};
        end
      end
      ST_DATA: if (accept) begin
        csum_d = csum_q ^ in_data;
        if (last_byte) begin
          mem_addr_d   = addr_ptr_q;
          addr_ptr_d   = addr_ptr_q + 1'b1;
          words_left_d = words_left_q - 16'd1;
          if (words_left_q == 16'd1) state_d = ST_CSUM;
        end
      end
      ST_CSUM: if (accept) begin
        state_d = ST_RESP;
        busy_d  = 1'b0;
        if (in_data == csum_q) begin
          done_d     = 1'b1;
          cpu_hold_d = 1'b0;
        end else begin
          error_d = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset clears everything and re-asserts the CPU hold.
  // NOTE: the datapath registers are reset too because their post-reset output values are defined, not just the control flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hdr_idx_q    <= '0;
      hdr_q        <= '0;
      words_left_q <= '0;
      addr_ptr_q   <= '0;
      mem_addr_q   <= '0;
      csum_q       <= '0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_idx_q    <= hdr_idx_d;
      hdr_q        <= hdr_d;
      words_left_q <= words_left_d;
      addr_ptr_q   <= addr_ptr_d;
      mem_addr_q   <= mem_addr_d;
      csum_q       <= csum_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

endmodule
